// File: rtl/fu_pkg.sv
// Shared types and defaults for the execution-unit functional units.
package fu_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  localparam int MUL_LATENCY_DEFAULT = 6;

endpackage

// File: rtl/fu_delay_line.sv
// Generic WIDTH x DEPTH shift register with per-stage valid, global enable and flush.
module fu_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else if (en) begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
      end
      // Payload only matters where valid is set, so flush leaves it alone.
      if (en) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/pipelined_mul_unit.sv
// Fully pipelined RV32M multiplier unit: product formed into stage 0, later stages
// delay it; the whole pipe stalls when writeback is not granted.
module pipelined_mul_unit
  import fu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int LATENCY = MUL_LATENCY_DEFAULT,
  parameter int RD_W    = 5,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  mul_op_e                        issue_op,
  input  logic [XLEN-1:0]                issue_a,
  input  logic [XLEN-1:0]                issue_b,
  input  logic [RD_W-1:0]                issue_rd,
  input  logic [TAG_W-1:0]               issue_tag,
  input  logic                           flush,
  output logic                           wb_valid,
  input  logic                           wb_ready,
  output logic [XLEN-1:0]                wb_data,
  output logic [RD_W-1:0]                wb_rd,
  output logic [TAG_W-1:0]               wb_tag,
  output logic                           busy,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [RD_W-1:0]  rd;
    logic [TAG_W-1:0] tag;
  } stage_t;

  localparam int CW = $clog2(LATENCY+1);

  logic              stall, fire, handshake;
  logic              a_sign, b_sign;
  logic [2*XLEN-1:0] a_wide, b_wide, prod;
  stage_t            s0_d, s0_q, last_q;
  logic              s0_valid, last_valid;

  assign stall       = last_valid && !wb_ready;
  assign issue_ready = !stall;
  assign fire        = issue_valid && issue_ready && !flush;
  assign handshake   = last_valid && wb_ready;

  // Modular 2*XLEN multiply of sign/zero-extended operands gives the exact product.
  always_comb begin
    a_sign    = (issue_op != MULHU) && issue_a[XLEN-1];
    b_sign    = ((issue_op == MUL) || (issue_op == MULH)) && issue_b[XLEN-1];
    a_wide    = {{XLEN{a_sign}}, issue_a};
    b_wide    = {{XLEN{b_sign}}, issue_b};
    prod      = a_wide * b_wide;
    s0_d.data = (issue_op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    s0_d.rd   = issue_rd;
    s0_d.tag  = issue_tag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_valid <= 1'b0;
      s0_q     <= '0;
    end else if (flush) begin
      s0_valid <= 1'b0;
    end else if (!stall) begin
      s0_valid <= fire;
      if (fire) s0_q <= s0_d;
    end
  end

  generate
    if (LATENCY > 1) begin : g_delay
      fu_delay_line #(
        .WIDTH ($bits(stage_t)),
        .DEPTH (LATENCY-1)
      ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .en        (!stall),
        .flush     (flush),
        .in_valid  (s0_valid),
        .in_data   (s0_q),
        .out_valid (last_valid),
        .out_data  (last_q)
      );
    end else begin : g_nodelay
      assign last_valid = s0_valid;
      assign last_q     = s0_q;
    end
  endgenerate

  assign wb_valid = last_valid;
  assign wb_data  = last_q.data;
  assign wb_rd    = last_q.rd;
  assign wb_tag   = last_q.tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (fire && !handshake) begin
      inflight <= inflight + CW'(1);
    end else if (!fire && handshake) begin
      inflight <= inflight - CW'(1);
    end
  end

  assign busy = (inflight != '0);

endmodule

// File: tb/tb_pipelined_mul_unit.sv
// Scoreboard bench for pipelined_mul_unit: issue side pushes expected results,
// a negedge monitor compares whatever the unit presents on writeback.
module tb_pipelined_mul_unit;
  import fu_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = 6;
  localparam int RD_W = 5;
  localparam int TAG_W = 4;
  localparam int CW   = $clog2(LAT+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic             issue_ready;
  mul_op_e          issue_op;
  logic [XLEN-1:0]  issue_a, issue_b;
  logic [RD_W-1:0]  issue_rd;
  logic [TAG_W-1:0] issue_tag;
  logic             flush;
  logic             wb_valid, wb_ready;
  logic [XLEN-1:0]  wb_data;
  logic [RD_W-1:0]  wb_rd;
  logic [TAG_W-1:0] wb_tag;
  logic             busy;
  logic [CW-1:0]    inflight;

  pipelined_mul_unit #(
    .XLEN(XLEN), .LATENCY(LAT), .RD_W(RD_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_tag(wb_tag), .busy(busy), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [RD_W-1:0]  rd;
    logic [TAG_W-1:0] tag;
    int               cyc;
    bit               chk_lat;
  } exp_t;

  exp_t            sbq[$];
  int              cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] drv_exp;
  bit              drv_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor first, then record this cycle's fire so push/pop never race.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb actual=valid data=%0h rd=%0d tag=%0d expected=no result (t=%0t)",
                 wb_data, wb_rd, wb_tag, $time);
      end else begin
        chk("wb_data", wb_data, sbq[0].data);
        chk("wb_rd", wb_rd, sbq[0].rd);
        chk("wb_tag", wb_tag, sbq[0].tag);
        if (sbq[0].chk_lat) begin
          chk("wb_latency", cyc - sbq[0].cyc, LAT);
          sbq[0].chk_lat = 1'b0;
        end
        if (wb_ready) void'(sbq.pop_front());
      end
    end
    if (reset || flush) sbq.delete();
    else if (issue_valid && issue_ready)
      sbq.push_back('{data: drv_exp, rd: issue_rd, tag: issue_tag, cyc: cyc, chk_lat: drv_lat});
  end

  task automatic issue(input mul_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RD_W-1:0] rd, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] exp, input bit lat);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_rd    = rd;
    issue_tag   = tag;
    drv_exp     = exp;
    drv_lat     = lat;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_op = MUL; issue_a = '0; issue_b = '0;
    issue_rd = '0; issue_tag = '0; flush = 1'b0; wb_ready = 1'b1; drv_exp = '0; drv_lat = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_wb_data", wb_data, 0);
    reset = 1'b0;
    idle(1);
    chk("rst_issue_ready", issue_ready, 1);

    // 1: single MUL
    issue(MUL, 32'd7, 32'd6, 5'd3, 4'd1, 32'd42, 1'b1);
    idle(10);

    // 2: six back-to-back MULs
    for (int i = 1; i <= 6; i++)
      issue(MUL, XLEN'(i), XLEN'(i+1), RD_W'(i), TAG_W'(i), XLEN'(i*(i+1)), 1'b1);
    chk("inflight_peak", inflight, 6);
    idle(8);
    chk("drained_inflight", inflight, 0);

    // 3: modes on the corner operands
    issue(MUL,    32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 4'd0, 32'h8000_0000, 1'b1);
    issue(MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 4'd1, 32'h0000_0000, 1'b1);
    issue(MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 4'd2, 32'h8000_0000, 1'b1);
    issue(MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 4'd3, 32'h7FFF_FFFF, 1'b1);
    idle(8);

    // 4: backpressure with 3 in flight
    wb_ready = 1'b0;
    issue(MUL,   32'd3,         32'd5,         5'd1, 4'd2, 32'd15,        1'b0);
    issue(MUL,   32'd100,       32'd200,       5'd2, 4'd3, 32'd20000,     1'b0);
    issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 4'd4, 32'hFFFF_FFFE, 1'b0);
    idle(8);
    chk("stall_issue_ready", issue_ready, 0);
    chk("stall_wb_valid", wb_valid, 1);
    chk("stall_inflight", inflight, 3);
    issue(MUL, 32'd9, 32'd9, 5'd9, 4'd9, 32'd81, 1'b0);   // must be refused
    chk("stall_refuse_inflight", inflight, 3);
    wb_ready = 1'b1;
    idle(1);
    chk("drain_inflight_2", inflight, 2);
    idle(1);
    chk("drain_inflight_1", inflight, 1);
    idle(6);
    chk("drain_done", inflight, 0);

    // 5: flush with 4 in flight plus a same-cycle issue
    for (int i = 0; i < 4; i++)
      issue(MUL, XLEN'(i+2), 32'd3, RD_W'(20+i), TAG_W'(i), XLEN'((i+2)*3), 1'b1);
    chk("preflush_inflight", inflight, 4);
    issue_valid = 1'b1; issue_op = MUL; issue_a = 32'd11; issue_b = 32'd11;
    issue_rd = 5'd30; issue_tag = 4'd15; drv_exp = 32'd121; drv_lat = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    issue_valid = 1'b0; flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_inflight", inflight, 0);
    idle(10);

    // 6: reset mid-pipe
    for (int i = 0; i < 3; i++)
      issue(MUL, XLEN'(i+1), 32'd10, RD_W'(i+1), TAG_W'(i+5), XLEN'((i+1)*10), 1'b1);
    reset = 1'b1;
    #1;
    chk("mrst_wb_valid", wb_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_inflight", inflight, 0);
    chk("mrst_wb_data", wb_data, 0);
    chk("mrst_wb_rd", wb_rd, 0);
    chk("mrst_wb_tag", wb_tag, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst_issue_ready", issue_ready, 1);
    idle(10);
    issue(MUL, 32'hFFFF_FFFF, 32'd5, 5'd7, 4'd9, 32'hFFFF_FFFB, 1'b1);
    idle(8);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
